// File: rtl/ram_slot_arbiter.sv
// Per-slot DRAM ownership arbiter: even slots carry video/refresh, odd slots carry DMA/blitter/CPU.
// Decisions happen only on slot_en edges and are held for the whole slot.
module ram_slot_arbiter #(
    parameter int unsigned REFRESH_DIV = 32,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic       clk32,
    input  logic       resb,
    input  logic       slot_en,
    input  logic       vid_req,
    input  logic       dma_req,
    input  logic       blit_req,
    input  logic       cpu_req,
    output logic [4:0] gnt,
    output logic [2:0] owner,
    output logic       slot_odd,
    output logic       slot_done,
    output logic [1:0] ref_pending
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned STV_W = 4;
    localparam int unsigned GNT_W = 5;

    typedef enum logic {
        SYNC,
        RUN
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [STV_W-1:0] starve;

    logic             next_odd_c;
    logic [GNT_W-1:0] gnt_c;
    logic [2:0]       owner_c;
    logic             ref_inc_c;
    logic             ref_dec_c;
    logic             cpu_forced_c;

    // Parity of the incoming slot: the first slot after SYNC is always even.
    assign next_odd_c   = (state == RUN) ? ~slot_odd : 1'b0;
    assign cpu_forced_c = (starve == STV_W'(STARVE_MAX)) && cpu_req;
    assign ref_inc_c    = (state == RUN || state == SYNC) && (div == DIV_W'(REFRESH_DIV - 1));
    assign ref_dec_c    = gnt_c[1];

    // Owner selection for the incoming slot.
    always_comb begin
        gnt_c = '0;
        if (!next_odd_c) begin
            if (ref_pending == 2'd3)      gnt_c = 5'b00010;
            else if (vid_req)             gnt_c = 5'b00001;
            else if (ref_pending != 2'd0) gnt_c = 5'b00010;
        end else begin
            if (cpu_forced_c)             gnt_c = 5'b10000;
            else if (dma_req)             gnt_c = 5'b00100;
            else if (blit_req)            gnt_c = 5'b01000;
            else if (cpu_req)             gnt_c = 5'b10000;
        end
    end

    always_comb begin
        owner_c = '0;
        for (int i = 0; i < int'(GNT_W); i++) begin
            if (gnt_c[i]) owner_c = 3'(i + 1);
        end
    end

    // Slot state, refresh bookkeeping and CPU starvation tracking.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            state       <= SYNC;
            gnt         <= '0;
            owner       <= '0;
            slot_odd    <= 1'b0;
            slot_done   <= 1'b0;
            ref_pending <= '0;
            div         <= '0;
            starve      <= '0;
        end else begin
            slot_done <= 1'b0;
            if (slot_en) begin
                state     <= RUN;
                slot_odd  <= next_odd_c;
                gnt       <= gnt_c;
                owner     <= owner_c;
                slot_done <= (state == RUN) && (owner != 3'd0);

                div <= ref_inc_c ? '0 : div + DIV_W'(1);

                if (ref_inc_c && !ref_dec_c && ref_pending != 2'd3) begin
                    ref_pending <= ref_pending + 2'd1;
                end else if (!ref_inc_c && ref_dec_c) begin
                    ref_pending <= ref_pending - 2'd1;
                end

                if (next_odd_c) begin
                    if (cpu_req && !gnt_c[4]) begin
                        if (starve != STV_W'(STARVE_MAX)) starve <= starve + STV_W'(1);
                    end else begin
                        starve <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/ram_slot_arbiter.md
Name: ram_slot_arbiter

Overview:
Shares the DRAM between video, refresh, DMA, blitter and CPU on fixed 500 ns memory slots.
Slot boundaries come from the clock generator's cycsel_en strobe, which is one clk32 cycle before cycsel rises.
Slots alternate between two kinds: even slots carry video or refresh, odd slots carry a bus master.
Each slot has at most one owner. Ownership is decided once per slot, and the RAS/CAS sequencer consumes the resulting grant.

Parameters:
REFRESH_DIV, 32, number of slots between refresh requests (range 2..255).
STARVE_MAX, 4, number of consecutive odd slots the CPU may lose before it is forced (range 1..15).

Ports:
clk32  input  1  32 MHz system clock; all state updates on its rising edge.
resb  input  1  asynchronous, active-low reset.
slot_en  input  1  one-cycle strobe, one clk32 before each slot boundary (cycsel_en).
vid_req  input  1  video shifter wants the next even slot.
dma_req  input  1  DMA wants an odd slot.
blit_req  input  1  blitter wants an odd slot.
cpu_req  input  1  CPU wants an odd slot.
gnt  output  5  one-hot grant for the current slot: bit0 vid, bit1 ref, bit2 dma, bit3 blit, bit4 cpu.
owner  output  3  encoded owner: 0 idle, 1 vid, 2 ref, 3 dma, 4 blit, 5 cpu.
slot_odd  output  1  parity of the current slot.
slot_done  output  1  one-cycle pulse: the slot that just ended had a non-idle owner.
ref_pending  output  2  outstanding refresh count.

Behaviour:
- Reset (resb low, asynchronous), all outputs and state cleared:
  - gnt=0, owner=0, slot_odd=0, slot_done=0, ref_pending=0.
  - Refresh divider=0, starve counter=0.
  - FSM goes to SYNC.
- FSM state SYNC:
  - No grants; no refresh counting.
  - The first slot_en moves the FSM to RUN and starts an even slot (slot_odd=0).
- FSM state RUN:
  - Each slot_en edge toggles slot_odd.
  - SYNC→RUN does not toggle; the first slot is even.
  - RUN has no exit except reset.
- Decision timing:
  - All decisions are made only on a clk32 edge with slot_en=1.
  - gnt, owner and slot_odd change on that edge, so they are valid from the cycsel-rise cycle.
  - They are held constant until the next slot_en edge.
  - Requests are sampled only at that edge. Dropping a request mid-slot does not revoke the grant.
  - Raising a request mid-slot has no effect until the next slot_en.
- slot_done:
  - Asserted on the slot_en edge whenever the outgoing owner was non-zero.
  - It pulses on the same edge as the new grant and lasts exactly one clk32.
  - It never fires in SYNC or on the SYNC→RUN edge.
- Refresh divider:
  - Counts slot_en edges in RUN, including the SYNC→RUN edge.
  - At REFRESH_DIV-1 it wraps to 0 and raises an increment.
  - ref_pending saturates at 3.
  - Granting refresh decrements ref_pending.
  - Increment and decrement on the same edge leave ref_pending unchanged.
  - At saturation with no decrement, the increment is dropped.
- Even-slot priority (decided for the incoming slot):
  1. ref_pending==3 → ref.
  2. Else vid_req → vid.
  3. Else ref_pending>0 → ref.
  4. Else idle.
  - dma, blit and cpu requests are ignored in even slots.
- Odd-slot priority:
  1. starve==STARVE_MAX and cpu_req → cpu.
  2. Else dma > blit > cpu.
  3. Else idle.
  - vid_req and refresh are ignored in odd slots.
- Starve counter (updated only on odd-slot decisions):
  - cpu_req=1 and not granted → increment, saturating at STARVE_MAX.
  - cpu granted, or cpu_req=0 → clear to 0.
- Invariants:
  - owner always equals the encoding of gnt.
  - gnt is always one-hot or zero.
  - slot_en arriving in back-to-back cycles is legal; each one is a full slot decision.
- Reset mid-slot: grant is removed immediately (asynchronously) and no slot_done is produced.

Test Plan:
- Release reset, then send slot_en every 16 clk32 with all requests low → slot_odd 0,1,0,1…; gnt=0 throughout; ref_pending reaches 1 at the 32nd slot_en (REFRESH_DIV=32).
- vid_req=1 and cpu_req=1 constant, ref_pending=0 → even slots gnt=00001, odd slots gnt=10000; slot_done pulses on every slot_en after the first.
- dma_req=1 and cpu_req=1 constant (STARVE_MAX=4) → odd slots grant dma 4 times, then cpu once, then dma 4 times again; starve counter returns to 0 after the cpu grant.
- Drive ref_pending to 3 with vid_req=1 constant → next even slot gnt=00010, ref_pending drops to 2; following even slots go to video while ref_pending>0 and <3.
- Increment and refresh grant on the same slot_en with ref_pending=1 → stays 1; with ref_pending=3 and no grant (odd slot) → stays 3.
- Assert resb low 5 cycles into a cpu-owned slot → gnt=0 and owner=0 immediately; no grants until the first slot_en after release; that slot is even.
